// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC + IMEM read handshake, IR capture, field decode, branch/sequential advance, halt on illegal opcode
module instruction_fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [7:0]  MAX_OPCODE = 8'd7
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [7:0]  branch_offset,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [7:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  rt,
  output logic [2:0]  rs,
  output logic [7:0]  immediate,
  output logic        halted
);
  typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, ir, ir_n;
  logic [31:0] br_step;
  logic        unused_ir;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc    <= PC_RESET;
      ir    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
    end
  assign br_step = branch_taken ? {{22{branch_offset[7]}}, branch_offset, 2'b00} : 32'd0;
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    case (state)
      IDLE:  state_n = REQ;
      REQ:   if (!imem_busywait) begin
               ir_n    = imem_readdata;
               state_n = (imem_readdata[31:24] > MAX_OPCODE) ? HALT : ISSUE;
             end
      ISSUE: if (!stall) begin
               state_n = REQ;
               pc_n    = pc + 32'd4 + br_step;
             end
      default: state_n = state;
    endcase
  end
  assign imem_read    = state == REQ;
  assign instr_valid  = state == ISSUE;
  assign halted       = state == HALT;
  assign imem_address = pc;
  assign pc_out       = pc;
  assign opcode       = ir[31:24];
  assign rd           = ir[18:16];
  assign rt           = ir[10:8];
  assign rs           = ir[2:0];
  assign immediate    = ir[7:0];
  // IR bits outside the decoded fields are kept only so IR holds the full word
  assign unused_ir    = ^{ir[23:19], ir[15:11]};
endmodule
